// File: rtl/cuenta_bits_pkg.sv
// Shared types and constants for the cuenta_bits population counter.
package cuenta_bits_pkg;

  localparam int W_DEF = 8;

  // Encoding keeps each busy/done flag on its own state bit.
  typedef enum logic [1:0] {
    INICIO = 2'b00,
    CUENTA = 2'b01,
    FIN    = 2'b10
  } estado_t;

endpackage : cuenta_bits_pkg

// File: rtl/cuenta_bits_fsm.sv
// Control FSM for cuenta_bits: INICIO -> CUENTA (W edges) -> FIN, plus the bit index.
module cuenta_bits_fsm
  import cuenta_bits_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int CW = $clog2(W + 1)
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    start_i,
  output estado_t state_o,
  output logic    accept_o,
  output logic    busy_o
);

  estado_t         state_q, state_d;
  logic [CW-1:0]   idx_q, idx_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= INICIO;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Leaving FIN needs start low, so a held start cannot retrigger a count.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      INICIO: begin
        if (start_i) begin
          state_d = CUENTA;
          idx_d   = '0;
        end
      end
      CUENTA: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == CW'(W - 1)) state_d = FIN;
      end
      FIN: begin
        if (!start_i) state_d = INICIO;
      end
      default: state_d = INICIO;
    endcase
  end

  assign state_o  = state_q;
  assign accept_o = (state_q == INICIO) && start_i;
  assign busy_o   = (state_q == CUENTA);

endmodule : cuenta_bits_fsm

// File: rtl/cuenta_bits.sv
// Serial bit counter: counts ones (or zeros with CUENTA_BITS_MODO_EN) of Valor, one bit per clock.
module cuenta_bits
  import cuenta_bits_pkg::*;
#(
  parameter  int W  = W_DEF,
  localparam int CW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [W-1:0]  Valor,
`ifdef CUENTA_BITS_MODO_EN
  input  logic          Modo,
`endif
  output logic [CW-1:0] Cuenta,
  output logic          Fin,
  output logic          Ocupado
);

  estado_t       state;
  logic          accept;
  logic          busy;
  logic [W-1:0]  shreg_q, shreg_d;
  logic [CW-1:0] acc_q, acc_d;
  logic          bitSel;

  cuenta_bits_fsm #(.W(W), .CW(CW)) u_fsm (
    .clk      (clk),
    .reset    (reset),
    .start_i  (start),
    .state_o  (state),
    .accept_o (accept),
    .busy_o   (busy)
  );

`ifdef CUENTA_BITS_MODO_EN
  logic modo_q, modo_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) modo_q <= 1'b0;
    else       modo_q <= modo_d;
  end

  always_comb begin
    modo_d = modo_q;
    if (accept) modo_d = Modo;
  end

  assign bitSel = shreg_q[0] ^ modo_q;
`else
  assign bitSel = shreg_q[0];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg_q <= '0;
      acc_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      acc_q   <= acc_d;
    end
  end

  // Operands are only sampled on the accepting edge; the accumulator holds its result afterwards.
  always_comb begin
    shreg_d = shreg_q;
    acc_d   = acc_q;
    if (accept) begin
      shreg_d = Valor;
      acc_d   = '0;
    end else if (busy) begin
      shreg_d = shreg_q >> 1;
      acc_d   = acc_q + {{(CW-1){1'b0}}, bitSel};
    end
  end

  assign Cuenta  = acc_q;
  assign Fin     = (state == FIN);
  assign Ocupado = busy;

endmodule : cuenta_bits

// File: tb/tb_cuenta_bits.sv
// Directed self-checking bench for cuenta_bits (W=8); Modo cases need CUENTA_BITS_MODO_EN.
module tb_cuenta_bits;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] Valor;
  logic       Modo;
  logic [3:0] Cuenta;
  logic       Fin;
  logic       Ocupado;

  int checkCount   = 0;
  int errorCount   = 0;
  int overlapCount = 0;

  cuenta_bits #(.W(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .Valor   (Valor),
`ifdef CUENTA_BITS_MODO_EN
    .Modo    (Modo),
`endif
    .Cuenta  (Cuenta),
    .Fin     (Fin),
    .Ocupado (Ocupado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Fin and Ocupado must never be high together.
  always @(negedge clk) begin
    if (Fin === 1'b1 && Ocupado === 1'b1) overlapCount++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Waits for Fin (bounded) and returns the number of negedges waited.
  task automatic waitFin(output int n);
    n = 0;
    while (Fin !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Pulses start for the accepting edge only, then checks latency and result.
  task automatic applyStimulus(input string tag, input logic [7:0] v, input logic m,
                               input int expCount);
    int n;
    Valor = v;
    Modo  = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput({tag, "_ocupado"}, Ocupado, 1);
    waitFin(n);
    checkOutput({tag, "_latency"}, n, 8);
    checkOutput({tag, "_cuenta"}, Cuenta, expCount);
    @(negedge clk);
    checkOutput({tag, "_finDrop"}, Fin, 0);
  endtask

  initial begin
    int n;
    int busyCycles;
    reset = 1'b1;
    start = 1'b0;
    Valor = 8'h00;
    Modo  = 1'b0;
    #2;
    checkOutput("reset_cuenta", Cuenta, 0);
    checkOutput("reset_fin", Fin, 0);
    checkOutput("reset_ocupado", Ocupado, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Start held high: 8 busy cycles, Fin on the 9th edge, held until start drops.
    Valor = 8'b1011_0010;
    start = 1'b1;
    busyCycles = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (Ocupado === 1'b1) busyCycles++;
      if (i == 3) Valor = 8'h00;
    end
    checkOutput("b2_busyCycles", busyCycles, 8);
    checkOutput("b2_fin9", Fin, 1);
    checkOutput("b2_cuenta", Cuenta, 4);
    repeat (3) @(negedge clk);
    checkOutput("b2_finHeld", Fin, 1);
    start = 1'b0;
    @(negedge clk);
    checkOutput("b2_finDrop", Fin, 0);
    checkOutput("b2_cuentaHold", Cuenta, 4);

    applyStimulus("v00", 8'h00, 1'b0, 0);
    applyStimulus("vFF", 8'hFF, 1'b0, 8);
    applyStimulus("v80", 8'h80, 1'b0, 1);

    // Valor changes mid-count must be ignored.
    Valor = 8'h0F;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    Valor = 8'hFF;
    Modo  = 1'b1;
    waitFin(n);
    checkOutput("latch_latency", n, 6);
    checkOutput("latch_cuenta", Cuenta, 4);
    @(negedge clk);
    Modo = 1'b0;

    // Reset in the middle of a count clears everything asynchronously.
    Valor = 8'hFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("mid_partial", Cuenta, 3);
    #2 reset = 1'b1;
    #1;
    checkOutput("rst_cuenta", Cuenta, 0);
    checkOutput("rst_fin", Fin, 0);
    checkOutput("rst_ocupado", Ocupado, 0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus("postRst", 8'h0F, 1'b0, 4);

    // Held start: one count only, then a one-cycle gap starts a second count.
    Valor = 8'h03;
    start = 1'b1;
    @(negedge clk);
    waitFin(n);
    checkOutput("held_cuenta1", Cuenta, 2);
    Valor = 8'h7F;
    busyCycles = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (Ocupado === 1'b1 || Fin !== 1'b1) busyCycles++;
    end
    checkOutput("held_noRetrigger", busyCycles, 0);
    checkOutput("held_cuentaKept", Cuenta, 2);
    start = 1'b0;
    @(negedge clk);
    checkOutput("gap_fin", Fin, 0);
    start = 1'b1;
    @(negedge clk);
    checkOutput("second_ocupado", Ocupado, 1);
    waitFin(n);
    checkOutput("second_latency", n, 8);
    checkOutput("second_cuenta", Cuenta, 7);
    start = 1'b0;
    @(negedge clk);

`ifdef CUENTA_BITS_MODO_EN
    applyStimulus("modoB2", 8'b1011_0010, 1'b1, 4);
    applyStimulus("modo01", 8'h01, 1'b1, 7);
    applyStimulus("modoOnes01", 8'h01, 1'b0, 1);
`endif

    checkOutput("fin_ocupado_overlap", overlapCount, 0);
    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule : tb_cuenta_bits

// File: doc/cuenta_bits.md
CUENTA_BITS -- requirements
Module: cuenta_bits

Interface
REQ-001 The block SHALL have parameter W, default 8, meaning the bit width of Valor (legal range 2..32).
REQ-002 The block SHALL have derived constant CW, default $clog2(W+1), meaning the width of Cuenta.
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, meaning reset, asynchronous and active-high.
REQ-005 The block SHALL have port start, input, 1, meaning the level-sensitive request to begin a count.
REQ-006 The block SHALL have port Valor, input, W, meaning the operand, sampled only when a count is accepted.
REQ-007 The block SHALL have port Modo, input, 1, meaning 0 = count ones and 1 = count zeros; it is present only with CUENTA_BITS_MODO_EN.
REQ-008 The block SHALL have port Cuenta, output, CW, meaning the result count, registered.
REQ-009 The block SHALL have port Fin, output, 1, meaning the result is valid, registered.
REQ-010 The block SHALL have port Ocupado, output, 1, meaning a count is in progress (high in state CUENTA).

Function
REQ-011 The block SHALL implement a FSM with the three states INICIO, CUENTA and FIN.
REQ-012 In INICIO with start=1 at an edge, the block SHALL latch Valor (and Modo) into an internal shift register, clear the accumulator and index, and go to CUENTA.
REQ-013 In CUENTA, each edge SHALL add the selected bit (shreg[0] for ones, ~shreg[0] for zeros) to the accumulator, shift shreg right by one, and increment the index.
REQ-014 In CUENTA, after exactly W cycles the block SHALL go to FIN, with latency of W+1 edges from the accepting edge to Fin=1.
REQ-015 In FIN, Fin SHALL be 1 and Cuenta SHALL equal the final accumulator; the block SHALL stay in FIN while start=1 and go to INICIO on the first edge with start=0.
REQ-016 Cuenta SHALL hold its last result through INICIO until the next accepting edge; during CUENTA it shows the running partial sum.
REQ-017 Fin SHALL drop on the edge leaving FIN, and Fin and Ocupado SHALL never be 1 together.
REQ-018 Changes on Valor or Modo outside the accepting edge SHALL have no effect on the count in progress.
REQ-019 start deasserting during CUENTA SHALL NOT abort the count; the block SHALL complete and enter FIN, then go to INICIO on the next edge.
REQ-020 The accumulator SHALL be CW bits wide and SHALL NOT overflow, so that all-ones with W=8 gives 8 = 4'b1000.
REQ-021 start held high continuously SHALL NOT retrigger a count; a new count requires a pass through INICIO, i.e. start=0 for at least one edge.

Reset
REQ-022 While reset=1, independent of clk, the block SHALL force state=INICIO, Cuenta=0, Fin=0, Ocupado=0, and clear the shift register and index.
REQ-023 Reset asserted mid-CUENTA or in FIN SHALL discard the operation; after release the block SHALL accept start on the first edge.

Configuration
REQ-024 With macro CUENTA_BITS_MODO_EN defined, the Modo port and zero-counting path SHALL exist per REQ-012/013.
REQ-025 With CUENTA_BITS_MODO_EN undefined, the Modo port SHALL be absent and the block SHALL always count ones, with timing otherwise identical.

Structure
REQ-026 Package cuenta_bits_pkg SHALL hold the state enum type (INICIO, CUENTA, FIN) and the default width constant W_DEF=8.
REQ-027 The FSM (state register, next-state logic, index counter) SHALL be split into sub-module cuenta_bits_fsm; the datapath (shift register, accumulator) stays in cuenta_bits.

Verification
REQ-028 The bench SHALL cover this scenario with W=8: Valor=8'b1011_0010, start pulse held -> Ocupado for 8 cycles, then Fin=1 with Cuenta=4 on the 9th edge, and Fin held until start=0.
REQ-029 The bench SHALL cover this scenario: Valor=8'h00, then 8'hFF -> Cuenta=0, then Cuenta=8, with no overflow.
REQ-030 The bench SHALL cover this scenario with MODO_EN: Valor=8'b1011_0010, Modo=1 -> Cuenta=4; Valor=8'h01, Modo=1 -> Cuenta=7.
REQ-031 The bench SHALL cover this scenario: Valor changed to 8'hFF at cycle 3 of a count of 8'h0F -> Cuenta=4 (latched value used).
REQ-032 The bench SHALL cover this scenario: reset pulsed at cycle 4 of CUENTA -> Cuenta=0, Fin=0, Ocupado=0 immediately, and the next start counts normally.
REQ-033 The bench SHALL cover this scenario: start held high across two FIN periods -> only one count occurs; start=0 for one cycle then 1 -> a second count of the new Valor.
